// File: rtl/spi_responder.sv
// spi_responder: SPI slave endpoint.
// Oversamples spi_clk / spi_cs_n / spi_mosi in the clk domain, shifts words
// MSB-first with runtime cpol/cpha/word_size, returns MISO data from a
// one-word transmit holding register, and stores received words in a
// first-word-fall-through RX FIFO.
// Ports:
//   clk, reset             system clock, async active-high reset
//   cpol, cpha, word_size  bus mode and bits-per-word minus one
//   spi_clk, spi_cs_n, spi_mosi, spi_miso, miso_oe   SPI bus side
//   tx_data, tx_valid, tx_ready                       transmit holding register
//   rx_data, rx_read, rx_empty, rx_full               RX FIFO head / pop / status
//   rx_overflow, tx_underrun, clear_flags             sticky error flags
//   busy                                              selected (not IDLE)
module spi_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [4:0]  word_size,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        miso_oe,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  input  logic        rx_read,
  output logic        rx_empty,
  output logic        rx_full,
  output logic        rx_overflow,
  output logic        tx_underrun,
  input  logic        clear_flags,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic sclk_prev_r, cs_prev_r;
  logic sclk_s, cs_s, mosi_s;
  logic lead_s, trail_s, sample_edge_s, shift_edge_s, cs_fall_s, cs_rise_s;
  logic [1:0] state_r, state_next_s;
  logic load_s, sample_s, shift_s, last_s;
  logic [4:0]  bit_cnt_r;
  logic [31:0] rx_shift_r, shift_out_r, tx_hold_r, ld_word_s, word_mask_s;
  logic tx_ready_r, ld_empty_r, underrun_r, push_r, overflow_r;
  logic spi_miso_r, miso_oe_r, busy_r;
  logic [31:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_next_s;
  logic [AW:0]   count_r, count_next_s;
  logic [31:0] rx_data_r, push_data_s;
  logic rx_empty_r, rx_full_r;
  logic pop_s, push_s, drop_s, full_s, head_from_push_s;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_s        = (sclk_s != cpol) && (sclk_prev_r == cpol);
  assign trail_s       = (sclk_s == cpol) && (sclk_prev_r != cpol);
  assign sample_edge_s = cpha ? trail_s : lead_s;
  assign shift_edge_s  = cpha ? lead_s : trail_s;
  assign cs_fall_s     = cs_prev_r && !cs_s;
  assign cs_rise_s     = !cs_prev_r && cs_s;

  assign word_mask_s = 32'hFFFF_FFFF >> (5'd31 - word_size);
  assign ld_word_s   = tx_ready_r ? 32'h0000_0000 : tx_hold_r;

  // Input synchronizers and one-flop edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state logic; a deselect wins in every state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  if (cs_fall_s) state_next_s = ST_LOAD; else state_next_s = ST_IDLE;
      ST_LOAD:  if (cs_rise_s) state_next_s = ST_IDLE; else state_next_s = ST_SHIFT;
      ST_SHIFT: begin
        if (cs_rise_s)                                  state_next_s = ST_IDLE;
        else if (sample_edge_s && (bit_cnt_r == 5'd0)) state_next_s = ST_LOAD;
        else                                            state_next_s = ST_SHIFT;
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // FSM output strobes; SCLK edges seen during LOAD are ignored.
  always_comb begin
    load_s   = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      ST_LOAD:  load_s = !cs_rise_s;
      ST_SHIFT: begin
        if (!cs_rise_s) begin
          sample_s = sample_edge_s;
          shift_s  = shift_edge_s;
          last_s   = sample_edge_s && (bit_cnt_r == 5'd0);
        end else begin
          sample_s = 1'b0;
        end
      end
      default:  load_s = 1'b0;
    endcase
  end

  // Bit counter, shift registers and the MISO/enable output flops.
  // MISO always presents shift_out[bit_cnt], so a stray trailing edge after a
  // back-to-back reload just re-drives the new MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_r   <= 5'd0;
      rx_shift_r  <= 32'h0000_0000;
      shift_out_r <= 32'h0000_0000;
      push_r      <= 1'b0;
      spi_miso_r  <= 1'b0;
      miso_oe_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      push_r    <= last_s;
      miso_oe_r <= (state_next_s != ST_IDLE);
      busy_r    <= (state_next_s != ST_IDLE);
      if (sample_s) rx_shift_r <= {rx_shift_r[30:0], mosi_s};
      else          rx_shift_r <= rx_shift_r;
      if (load_s) shift_out_r <= ld_word_s;
      else        shift_out_r <= shift_out_r;
      if (state_next_s == ST_IDLE) bit_cnt_r <= 5'd0;
      else if (load_s)             bit_cnt_r <= word_size;
      else if (sample_s)           bit_cnt_r <= bit_cnt_r - 5'd1;
      else                         bit_cnt_r <= bit_cnt_r;
      if (state_next_s == ST_IDLE)  spi_miso_r <= 1'b0;
      else if (load_s && !cpha)     spi_miso_r <= ld_word_s[word_size];
      else if (shift_s)             spi_miso_r <= shift_out_r[bit_cnt_r];
      else                          spi_miso_r <= spi_miso_r;
    end
  end

  // Transmit holding register and underrun tracking. An empty load is only
  // reported once the word actually starts (first sample edge), so the
  // speculative reload after a word's last bit is harmless if CS then rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_hold_r  <= 32'h0000_0000;
      tx_ready_r <= 1'b1;
      ld_empty_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (tx_valid && tx_ready_r) begin
        tx_hold_r  <= tx_data;
        tx_ready_r <= 1'b0;
      end else if (load_s) begin
        tx_ready_r <= 1'b1;
      end else begin
        tx_ready_r <= tx_ready_r;
      end
      if (state_next_s == ST_IDLE) ld_empty_r <= 1'b0;
      else if (load_s)             ld_empty_r <= tx_ready_r;
      else if (sample_s)           ld_empty_r <= 1'b0;
      else                         ld_empty_r <= ld_empty_r;
      if (clear_flags)                  underrun_r <= 1'b0;
      else if (sample_s && ld_empty_r)  underrun_r <= 1'b1;
      else                              underrun_r <= underrun_r;
    end
  end

  assign full_s       = (count_r == CNT_FULL);
  assign pop_s        = rx_read && (count_r != CNT_ZERO);
  assign push_s       = push_r && (!full_s || pop_s);
  assign drop_s       = push_r && full_s && !pop_s;
  assign push_data_s  = rx_shift_r & word_mask_s;
  assign count_next_s = count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
  assign rd_ptr_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
  // Pushed word becomes the head when nothing else remains after the pop.
  assign head_from_push_s = push_s && ((count_r == CNT_ZERO) || (pop_s && (count_r == CNT_ONE)));

  // RX FIFO storage (no reset needed; head register masks stale data).
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= push_data_s;
    else        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
  end

  // RX FIFO pointers, count, registered head and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= CNT_ZERO;
      rx_data_r  <= 32'h0000_0000;
      rx_empty_r <= 1'b1;
      rx_full_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      rd_ptr_r   <= rd_ptr_next_s;
      wr_ptr_r   <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
      count_r    <= count_next_s;
      rx_empty_r <= (count_next_s == CNT_ZERO);
      rx_full_r  <= (count_next_s == CNT_FULL);
      if (count_next_s == CNT_ZERO) rx_data_r <= 32'h0000_0000;
      else if (head_from_push_s)    rx_data_r <= push_data_s;
      else                          rx_data_r <= mem_r[rd_ptr_next_s];
      if (clear_flags) overflow_r <= 1'b0;
      else if (drop_s) overflow_r <= 1'b1;
      else             overflow_r <= overflow_r;
    end
  end

  assign spi_miso    = spi_miso_r;
  assign miso_oe     = miso_oe_r;
  assign busy        = busy_r;
  assign tx_ready    = tx_ready_r;
  assign tx_underrun = underrun_r;
  assign rx_data     = rx_data_r;
  assign rx_empty    = rx_empty_r;
  assign rx_full     = rx_full_r;
  assign rx_overflow = overflow_r;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a bit-banged SPI master drives the
// bus; expected RX words and expected MISO words are queued when stimulus is
// issued and compared when the DUT delivers them.
module tb_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic [4:0]  word_size = 5'd7;
  logic        spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso, miso_oe;
  logic [31:0] tx_data = 32'h0;
  logic        tx_valid = 1'b0, tx_ready;
  logic [31:0] rx_data;
  logic        rx_read = 1'b0, rx_empty, rx_full, rx_overflow, tx_underrun;
  logic        clear_flags = 1'b0, busy;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] rx_exp_q[$];
  logic [31:0] tx_exp_q[$];
  logic [31:0] miso_w;

  always #10 clk = ~clk;

  spi_responder #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .word_size(word_size),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_read(rx_read), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .clear_flags(clear_flags), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tx_put(input logic [31:0] w);
    int n = 0;
    while (!tx_ready && n < 400) begin @(negedge clk); n++; end
    if (!tx_ready) check_eq("tx_ready_wait", {31'b0, tx_ready}, 32'h1);
    else begin
      tx_data = w; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_exp_q.push_back(w & (32'hFFFF_FFFF >> (5'd31 - word_size)));
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_clk = cpol; spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shift bits n-1..0 of w; master captures MISO on its sample edge.
  task automatic shift_bits(input logic [31:0] w, input int n, output logic [31:0] m);
    m = 32'h0;
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        spi_mosi = w[i];
        repeat (4) @(negedge clk);
        spi_clk = ~cpol; m = {m[30:0], spi_miso};
        repeat (8) @(negedge clk);
        spi_clk = cpol;
        repeat (4) @(negedge clk);
      end else begin
        spi_clk = ~cpol; spi_mosi = w[i];
        repeat (8) @(negedge clk);
        spi_clk = cpol; m = {m[30:0], spi_miso};
        repeat (8) @(negedge clk);
      end
    end
  endtask

  task automatic xfer(input logic [31:0] w, input bit expect_rx);
    cs_low();
    shift_bits(w, int'(word_size) + 1, miso_w);
    cs_high();
    if (expect_rx) rx_exp_q.push_back(w & (32'hFFFF_FFFF >> (5'd31 - word_size)));
  endtask

  task automatic miso_check(input string tag);
    if (tx_exp_q.size() == 0) check_eq({tag, "_noexp"}, miso_w, 32'hDEAD_BEEF);
    else check_eq(tag, miso_w, tx_exp_q.pop_front());
  endtask

  task automatic read_check(input string tag);
    int n = 0;
    while (rx_empty && n < 50) begin @(negedge clk); n++; end
    if (rx_empty) check_eq({tag, "_wait"}, {31'b0, rx_empty}, 32'h0);
    else if (rx_exp_q.size() == 0) check_eq({tag, "_noexp"}, rx_data, 32'hDEAD_BEEF);
    else begin
      check_eq(tag, rx_data, rx_exp_q.pop_front());
      rx_read = 1'b1;
      @(negedge clk);
      rx_read = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic set_mode(input logic p, input logic h, input logic [4:0] ws);
    @(negedge clk);
    cpol = p; cpha = h; word_size = ws; spi_clk = p;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check_eq("rst_miso", {31'b0, spi_miso}, 32'h0);
    check_eq("rst_oe", {31'b0, miso_oe}, 32'h0);
    check_eq("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
    check_eq("rst_rx_data", rx_data, 32'h0);
    check_eq("rst_rx_empty", {31'b0, rx_empty}, 32'h1);
    check_eq("rst_rx_full", {31'b0, rx_full}, 32'h0);
    check_eq("rst_ovf", {31'b0, rx_overflow}, 32'h0);
    check_eq("rst_unr", {31'b0, tx_underrun}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0, 8-bit: tx 0xA5, master sends 0xCE
    set_mode(1'b0, 1'b0, 5'd7);
    tx_put(32'hA5);
    check_eq("m0_tx_busy", {31'b0, tx_ready}, 32'h0);
    cs_low();
    check_eq("m0_tx_ready_after_load", {31'b0, tx_ready}, 32'h1);
    check_eq("m0_oe_selected", {31'b0, miso_oe}, 32'h1);
    shift_bits(32'hCE, 8, miso_w);
    cs_high();
    rx_exp_q.push_back(32'hCE);
    miso_check("m0_miso");
    check_eq("m0_unr", {31'b0, tx_underrun}, 32'h0);
    read_check("m0_rx");

    // Mode 3, 16-bit
    set_mode(1'b1, 1'b1, 5'd15);
    tx_put(32'h1234);
    xfer(32'hBEEF, 1'b1);
    miso_check("m3_miso");
    read_check("m3_rx");

    // Mode 1 back-to-back, 8-bit, CS held low
    set_mode(1'b0, 1'b1, 5'd7);
    tx_put(32'h33);
    cs_low();
    tx_put(32'h44);
    shift_bits(32'h11, 8, miso_w);
    rx_exp_q.push_back(32'h11);
    miso_check("b2b_miso0");
    shift_bits(32'h22, 8, miso_w);
    rx_exp_q.push_back(32'h22);
    miso_check("b2b_miso1");
    cs_high();
    check_eq("b2b_unr", {31'b0, tx_underrun}, 32'h0);
    read_check("b2b_rx0");
    read_check("b2b_rx1");

    // Partial word discarded, then a full word
    set_mode(1'b0, 1'b0, 5'd7);
    tx_put(32'hFF);
    void'(tx_exp_q.pop_back());
    cs_low();
    shift_bits(32'h5, 3, miso_w);
    cs_high();
    check_eq("idle_miso", {31'b0, spi_miso}, 32'h0);
    check_eq("idle_oe", {31'b0, miso_oe}, 32'h0);
    check_eq("idle_busy", {31'b0, busy}, 32'h0);
    check_eq("partial_empty", {31'b0, rx_empty}, 32'h1);
    tx_put(32'h0F);
    xfer(32'h5A, 1'b1);
    miso_check("partial_next_miso");
    read_check("partial_rx");
    check_eq("partial_only_one", {31'b0, rx_empty}, 32'h1);
    check_eq("pre_ovf_unr", {31'b0, tx_underrun}, 32'h0);

    // 17 words without reads; no tx data so MISO is zero and underrun sets
    for (int i = 0; i < 17; i++) begin
      xfer(32'((i * 7 + 3) & 8'hFF), i < 16);
      if (i == 0) begin
        tx_exp_q.push_back(32'h0);
        miso_check("unr_miso_zero");
        check_eq("unr_flag", {31'b0, tx_underrun}, 32'h1);
      end
    end
    check_eq("ovf_full", {31'b0, rx_full}, 32'h1);
    check_eq("ovf_flag", {31'b0, rx_overflow}, 32'h1);
    for (int i = 0; i < 16; i++) read_check("ovf_rx");
    check_eq("ovf_drained", {31'b0, rx_empty}, 32'h1);
    check_eq("ovf_not_full", {31'b0, rx_full}, 32'h0);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check_eq("clr_ovf", {31'b0, rx_overflow}, 32'h0);
    check_eq("clr_unr", {31'b0, tx_underrun}, 32'h0);

    // Async reset mid-word with data in the FIFO and holding register
    tx_put(32'h77);
    void'(tx_exp_q.pop_back());
    xfer(32'h3C, 1'b0);
    cs_low();
    shift_bits(32'h6, 3, miso_w);
    tx_put(32'h55);
    void'(tx_exp_q.pop_back());
    check_eq("pre_rst_busy", {31'b0, busy}, 32'h1);
    check_eq("pre_rst_rx", rx_data, 32'h3C);
    reset = 1'b1;
    #1;
    check_eq("arst_miso", {31'b0, spi_miso}, 32'h0);
    check_eq("arst_oe", {31'b0, miso_oe}, 32'h0);
    check_eq("arst_busy", {31'b0, busy}, 32'h0);
    check_eq("arst_tx_ready", {31'b0, tx_ready}, 32'h1);
    check_eq("arst_rx_data", rx_data, 32'h0);
    check_eq("arst_rx_empty", {31'b0, rx_empty}, 32'h1);
    check_eq("arst_unr", {31'b0, tx_underrun}, 32'h0);
    spi_cs_n = 1'b1; spi_clk = cpol;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI slave (responder) endpoint for the GPIO SPI subsystem, the far end of our SPI master on the same four-wire bus. Oversamples spi_clk, spi_cs_n and spi_mosi in the clk domain, shifts words MSB-first with runtime mode and word size, and returns MISO data from a one-word transmit holding register. Received words go into an RX FIFO with first-word-fall-through read. Used as a loopback target on the board and as a bench peer for the master.

## Interface
- FIFO_DEPTH, 16: RX FIFO depth in words (power of two).
- SYNC_STAGES, 2: synchronizer flops per SPI input (≥2).
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- word_size  in  5  bits per word minus 1 (7 → 8-bit word, 31 → 32-bit word).
- spi_clk  in  1  bus SCLK.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- miso_oe  out  1  MISO output enable; high only while selected.
- tx_data  in  32  next word to return; bits [word_size:0] used.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- rx_data  out  32  FIFO head, zero-extended above word_size.
- rx_read  in  1  pop FIFO head.
- rx_empty  out  1  RX FIFO empty.
- rx_full  out  1  RX FIFO full.
- rx_overflow  out  1  sticky: a word was dropped.
- tx_underrun  out  1  sticky: a word started with an empty holding register.
- clear_flags  in  1  clears rx_overflow and tx_underrun.
- busy  out  1  selected (state ≠ IDLE).

## Operation
- Inputs pass through SYNC_STAGES flops, then a one-flop edge detector on the synchronized SCLK.
- Leading edge = SCLK leaving cpol; trailing edge = SCLK returning to cpol. Sample edge = leading if cpha=0, else trailing. Shift edge = the other edge.
- States: IDLE, LOAD, SHIFT.
- IDLE: miso_oe=0, spi_miso=0. Synchronized cs_n falling → LOAD.
- LOAD, one cycle: if the holding register is full, copy it to the shift-out register and free it (tx_ready=1 next cycle); otherwise load 0 and set tx_underrun. Bit counter = word_size. miso_oe=1. If cpha=0, drive the MSB at once. Go to SHIFT.
- SHIFT:
  - Each sample edge: shift sync MOSI into the RX shift register LSB, then decrement the counter.
  - Each shift edge: drive the next MISO bit. If cpha=1, the first leading edge drives the MSB.
  - On the sample edge where counter = 0: push the word into the RX FIFO and go to LOAD for a back-to-back word. In LOAD, cpha=0 drives the new MSB; leading edges are not counted as shift edges there.
- Synchronized cs_n rising in any state → IDLE, discarding the partial word. No push, counter reset, miso_oe=0 next cycle.
- TX handshake: tx_valid && tx_ready latches tx_data. tx_ready stays low until LOAD consumes the word. tx_valid while tx_ready=0 is ignored.
- RX FIFO: wrap-around pointers plus count.
  - rx_read while empty is ignored.
  - A push while full drops the word and sets rx_overflow, unless rx_read occurs the same cycle; then both happen and no flag is set.
- clear_flags has priority over a same-cycle set.
- Changes to cpol/cpha/word_size are legal only while busy=0.

## Timing
- Reset values: spi_miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_empty 1, rx_full 0, rx_overflow 0, tx_underrun 0, busy 0, state IDLE, FIFO pointers 0.
- Input-to-edge-detect latency: SYNC_STAGES+1 clk. spi_miso changes within SYNC_STAGES+2 clk of the physical SCLK shift edge.
- Requirement: SCLK high and low phases each ≥4 clk; CS-low to first SCLK edge ≥4 clk.
- Push occurs 1 clk after the final sample edge is detected. rx_empty falls, and rx_data is valid, the next clk.
- rx_read pops in the same cycle; the new head appears on rx_data the next clk.
- rx_full and rx_empty are registered and reflect the count after each cycle's push/pop.

## Test plan
- Mode 0, word_size=7, tx_data=0xA5 preloaded, master sends 0xCE → rx_data=0xCE and MISO sequence 1,0,1,0,0,1,0,1. tx_ready returns to 1 right after LOAD; tx_underrun=0.
- Mode 3, word_size=15, tx_data=0x1234, master sends 0xBEEF → rx_data=0x0000BEEF and master receives 0x1234.
- Back-to-back in mode 1 (word_size=7, CS held low): sends 0x11, 0x22; tx 0x33 then 0x44 supplied during word 1 → two pops in order 0x11, 0x22; MISO returns 0x33, 0x44.
- CS_n raised after 3 bits, then a full word 0x5A → FIFO holds only 0x5A. spi_miso 0 and miso_oe 0 in IDLE.
- 17 words with no rx_read (FIFO_DEPTH=16) → rx_full=1, rx_overflow=1, first 16 words intact. Then clear_flags → rx_overflow=0.
- Word started with tx_ready=1 → MISO all zeros, tx_underrun=1. Async reset mid-word → all outputs return to reset values immediately.
